fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the RV32 core.
- Decides when the PC register advances (pc_en) and drives a single-outstanding req/gnt/rvalid handshake to instruction memory.
- Presents fetched instructions to decode with a valid/ready handshake.
- Handles redirects (taken branch, JAL/JALR) by squashing wrong-path fetches, including responses already in flight.

Parameters:
- CNT_W, 32, width of the performance counters fetch_cnt and stall_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- run  in  1  fetch enable; when 0, no new request is issued
- pc  in  32  current PC register value
- redirect  in  1  branch taken or jump this cycle; the PC register's next value is the target
- pc_en  out  1  PC register load enable; loads pc+4 or the target, selected externally by redirect
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts
- inst  out  32  held instruction
- inst_pc  out  32  address of the held instruction
- fetch_cnt  out  CNT_W  number of instructions handed to decode
- stall_cnt  out  CNT_W  cycles spent in REQ/WAIT/DRAIN

Behaviour:
- Reset: state IDLE; pc_en=0, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, both counters 0. Instruction memory is reset on the same rst, so no stale rvalid is possible.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE:
  - run=1 -> REQ next cycle.
  - Otherwise remain.
- REQ:
  - imem_req=1, imem_addr=pc (combinational from pc; pc is stable while in REQ unless redirected).
  - gnt & ~redirect -> WAIT.
  - gnt & redirect -> DRAIN; the accepted address is wrong-path.
  - ~gnt & redirect -> stay REQ; imem_addr follows the new pc next cycle. Dropping the request is allowed because it was not granted.
- WAIT:
  - imem_req=0.
  - rvalid & ~redirect -> capture inst<=imem_rdata and inst_pc<=address of the granted request (registered at grant); go HOLD.
  - rvalid & redirect -> discard data, go REQ (or IDLE if run=0).
  - ~rvalid & redirect -> DRAIN.
- DRAIN:
  - Wait for rvalid, discard it, then go REQ (or IDLE if run=0).
  - A further redirect here only pulses pc_en; state is unchanged.
- HOLD:
  - inst_valid = (state==HOLD) & ~redirect, combinational.
  - inst_valid & inst_ready -> handoff: pc_en=1, fetch_cnt+1, go REQ (or IDLE if run=0).
  - redirect -> squash the held instruction (no handoff that cycle), go REQ (or IDLE if run=0).
- pc_en = handoff | redirect.
  - A single-cycle pulse per event; redirect pulses it in every state, including IDLE.
  - Handoff and redirect never coincide, by construction.
  - PC never advances except through pc_en.
- Latency: best case (gnt the same cycle as req, rvalid the next cycle) is 3 cycles per instruction: REQ, WAIT, HOLD with inst_ready=1.
- run=0 mid-transaction: the outstanding request is completed or drained and the held instruction is still offered; then IDLE.
- rvalid in IDLE, REQ or HOLD is a protocol error; it is ignored with no state change.
- Counters: stall_cnt +1 every cycle in REQ, WAIT or DRAIN. Both counters wrap modulo 2^CNT_W. Reset mid-operation clears them.
- Reset mid-transaction: returns to IDLE the next cycle. inst_valid drops immediately in the reset cycle's registered outputs, and no pc_en is issued.

Test Plan:
- Reset then run=1, pc=0x0, gnt same cycle, rvalid next cycle with 0x00500093, inst_ready=1 -> inst=0x00500093, inst_pc=0x0, single pc_en pulse, fetch_cnt=1; next imem_addr=0x4.
- gnt delayed 3 cycles, rvalid delayed 2 cycles -> imem_addr held stable throughout REQ, stall_cnt=6, exactly one handoff.
- Redirect in WAIT before rvalid (target 0x100) -> DRAIN, arriving rdata discarded (inst_valid never 1), next imem_addr=0x100.
- Redirect in HOLD while inst_ready=1 -> inst_valid=0 that cycle, fetch_cnt unchanged, pc_en=1 once, next request addresses the target.
- Redirect coincident with gnt in REQ -> DRAIN; the response is dropped and a new request is issued at the target.
- run deasserted in WAIT -> instruction still delivered, then IDLE with imem_req=0. Reset asserted in HOLD -> all outputs 0 and counters 0 the next cycle.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32 instruction-fetch sequencer. Issues one outstanding
// req/gnt/rvalid fetch at a time, holds the returned word for decode, and
// squashes wrong-path fetches (including in-flight responses) on redirect.
module fetch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      pc,
  input  logic             redirect,
  output logic             pc_en,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_gnt_addr;
  logic [31:0] r_inst, r_inst_pc;
  logic [CNT_W-1:0] r_fetch_cnt, r_stall_cnt;

  logic   w_inst_valid, w_handoff, w_capture, w_stall;
  state_t w_after;

  // Where to go once a fetch is finished (delivered, squashed or drained).
  assign w_after = run ? REQ : IDLE;

  // Output decode and next-state selection.
  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    // Reset gates the combinational outputs so no pc_en or valid leaks out
    // during the reset cycle itself.
    w_inst_valid = (r_state == HOLD) && !redirect && !rst;
    w_handoff    = w_inst_valid && inst_ready;
    w_stall      = (r_state == REQ) || (r_state == WAIT) || (r_state == DRAIN);
    case (r_state)
      IDLE:  if (run) w_next = REQ;
      REQ:   if (imem_gnt) w_next = redirect ? DRAIN : WAIT;
      WAIT: begin
        if (imem_rvalid && !redirect) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end else if (imem_rvalid && redirect) begin
          w_next = w_after;
        end else if (redirect) begin
          w_next = DRAIN;
        end
      end
      DRAIN: if (imem_rvalid) w_next = w_after;
      HOLD:  if (w_handoff || redirect) w_next = w_after;
      default: w_next = IDLE;
    endcase
  end

  assign imem_req   = (r_state == REQ);
  assign imem_addr  = (r_state == REQ) ? pc : 32'h0;
  assign pc_en      = !rst && (w_handoff || redirect);
  assign inst_valid = w_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fetch_cnt  = r_fetch_cnt;
  assign stall_cnt  = r_stall_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Latch the granted address and the returned instruction word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_addr <= '0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
    end else begin
      if ((r_state == REQ) && imem_gnt) r_gnt_addr <= pc;
      if (w_capture) begin
        r_inst    <= imem_rdata;
        r_inst_pc <= r_gnt_addr;
      end
    end
  end

  // Performance counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_handoff) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (w_stall)   r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change just after the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst, run, redirect, pc_en, imem_req, imem_gnt, imem_rvalid;
  logic        inst_valid, inst_ready;
  logic [31:0] pc, imem_addr, imem_rdata, inst, inst_pc, fetch_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .pc(pc), .redirect(redirect),
    .pc_en(pc_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; new inputs are set by the caller right after.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1; run = 0; pc = 0; redirect = 0; imem_gnt = 0; imem_rvalid = 0;
    imem_rdata = 0; inst_ready = 0;
    tick(); tick();
    rst = 0; settle();
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_pc_en", pc_en, 0);

    // Redirect in IDLE still pulses pc_en.
    redirect = 1; settle();
    chk("idle_redir_pc_en", pc_en, 1);
    tick(); redirect = 0;

    // T1: best-case fetch at 0x0.
    run = 1; pc = 32'h0; tick();
    imem_gnt = 1; settle();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_pc_en_req", pc_en, 0);
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00500093; settle();
    chk("t1_wait_req", imem_req, 0);
    chk("t1_wait_valid", inst_valid, 0);
    tick();
    imem_rvalid = 0; imem_rdata = 0; inst_ready = 1; settle();
    chk("t1_valid", inst_valid, 1);
    chk("t1_inst", inst, 32'h00500093);
    chk("t1_inst_pc", inst_pc, 32'h0);
    chk("t1_pc_en", pc_en, 1);
    tick();
    pc = 32'h4; inst_ready = 0; settle();
    chk("t1_pc_en_after", pc_en, 0);
    chk("t1_fetch_cnt", fetch_cnt, 1);
    chk("t1_next_addr", imem_addr, 32'h4);
    chk("t1_stall_cnt", stall_cnt, 2);

    // T2: gnt three cycles late, rvalid two cycles after gnt.
    rst = 1; tick();
    rst = 0; pc = 32'h20; tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_addr_stable", imem_addr, 32'h20);
      chk("t2_req", imem_req, 1);
      tick();
    end
    imem_gnt = 1; settle();
    chk("t2_addr_gnt", imem_addr, 32'h20);
    tick();
    imem_gnt = 0; settle();
    chk("t2_wait_valid", inst_valid, 0);
    tick();
    imem_rvalid = 1; imem_rdata = 32'h11111111; tick();
    imem_rvalid = 0; inst_ready = 1; settle();
    chk("t2_stall_cnt", stall_cnt, 6);
    chk("t2_inst_pc", inst_pc, 32'h20);
    chk("t2_inst", inst, 32'h11111111);
    chk("t2_pc_en", pc_en, 1);
    tick();
    pc = 32'h24; inst_ready = 0; settle();
    chk("t2_fetch_cnt", fetch_cnt, 1);
    chk("t2_pc_en_after", pc_en, 0);

    // T3: redirect in WAIT before rvalid -> DRAIN, response dropped.
    imem_gnt = 1; tick();
    imem_gnt = 0; redirect = 1; settle();
    chk("t3_pc_en", pc_en, 1);
    tick();
    redirect = 0; pc = 32'h100; imem_rvalid = 1; imem_rdata = 32'hdeadbeef; settle();
    chk("t3_drain_valid", inst_valid, 0);
    chk("t3_drain_req", imem_req, 0);
    chk("t3_drain_pc_en", pc_en, 0);
    tick();
    imem_rvalid = 0; settle();
    chk("t3_target_addr", imem_addr, 32'h100);
    chk("t3_valid", inst_valid, 0);

    // T4: redirect in HOLD with inst_ready high squashes the handoff.
    imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h22222222; tick();
    imem_rvalid = 0; inst_ready = 1; redirect = 1; settle();
    chk("t4_valid", inst_valid, 0);
    chk("t4_pc_en", pc_en, 1);
    tick();
    redirect = 0; inst_ready = 0; pc = 32'h200; settle();
    chk("t4_fetch_cnt", fetch_cnt, 1);
    chk("t4_pc_en_after", pc_en, 0);
    chk("t4_addr", imem_addr, 32'h200);

    // T5: redirect coincident with gnt -> DRAIN, then fetch the target.
    imem_gnt = 1; redirect = 1; settle();
    chk("t5_pc_en", pc_en, 1);
    tick();
    imem_gnt = 0; redirect = 0; pc = 32'h300; imem_rvalid = 1; imem_rdata = 32'hbadbad00; settle();
    chk("t5_drain_req", imem_req, 0);
    chk("t5_drain_valid", inst_valid, 0);
    tick();
    imem_rvalid = 0; settle();
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 32'h300);

    // T6: run drops in WAIT; instruction still delivered, then IDLE.
    imem_gnt = 1; tick();
    imem_gnt = 0; run = 0; imem_rvalid = 1; imem_rdata = 32'h33333333; tick();
    imem_rvalid = 0; inst_ready = 1; settle();
    chk("t6_valid", inst_valid, 1);
    chk("t6_inst", inst, 32'h33333333);
    chk("t6_inst_pc", inst_pc, 32'h300);
    tick();
    inst_ready = 0; pc = 32'h304; settle();
    chk("t6_idle_req", imem_req, 0);
    chk("t6_idle_valid", inst_valid, 0);
    chk("t6_fetch_cnt", fetch_cnt, 2);
    tick(); settle();
    chk("t6_idle_req2", imem_req, 0);

    // T7: reset asserted in HOLD.
    run = 1; tick();
    imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h44444444; tick();
    imem_rvalid = 0; settle();
    chk("t7_valid_pre", inst_valid, 1);
    rst = 1; inst_ready = 1; settle();
    chk("t7_rst_pc_en", pc_en, 0);
    chk("t7_rst_valid", inst_valid, 0);
    tick();
    rst = 0; run = 0; inst_ready = 0; settle();
    chk("t7_valid", inst_valid, 0);
    chk("t7_inst", inst, 0);
    chk("t7_inst_pc", inst_pc, 0);
    chk("t7_fetch_cnt", fetch_cnt, 0);
    chk("t7_stall_cnt", stall_cnt, 0);
    chk("t7_req", imem_req, 0);
    chk("t7_pc_en", pc_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
